// File: rtl/sat_difference_if.sv
// sat_difference_if: sample-in / result-out bundle of the saturating differentiator.
// master drives clear/in_valid/in_data and observes the result side;
// slave is the datapath side (consumes samples, produces results).
//
// Signals:
//   clear     synchronous flush of delay line, counter and output valid
//   in_valid  in_data carries a new sample this cycle
//   in_data   signed input sample x[n]
//   out_valid single-cycle pulse per accepted sample
//   out_data  signed saturated difference (held between results)
//   sat_flag  result was clamped (qualified by out_valid, held otherwise)
//   primed    at least D samples accepted since reset/clear
interface sat_difference_if #(
    parameter int N = 4
);
    logic         clear;
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         sat_flag;
    logic         primed;

    modport master (
        output clear,
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data,
        input  sat_flag,
        input  primed
    );

    modport slave (
        input  clear,
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data,
        output sat_flag,
        output primed
    );
endinterface

// File: rtl/sat_difference.sv
// Streaming saturating comb stage: y[n] = x[n] - x[n-D], symmetric clamp to +/-(2^(N-1)-1).
// Latency: 1 cycle from accepting edge to registered result; one sample per cycle.
// Backpressure: none; every in_valid cycle without clear is accepted.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (zeroes delay line, counter, outputs)
//   bus    sat_difference_if.slave: clear, in_valid, in_data -> out_valid, out_data,
//          sat_flag, primed
module sat_difference #(
    parameter int N = 4,
    parameter int D = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    sat_difference_if.slave bus
);

    localparam int            CW       = $clog2(D + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);
    // Symmetric limits: the most negative two's-complement code is never emitted.
    localparam logic [N-1:0]  POS_MAX  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  NEG_MAX  = {1'b1, {(N-2){1'b0}}, 1'b1};

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // taps[0] is the most recently accepted sample; taps[D-1] is x[n-D].
    // Zero-filled on reset/clear, so the tap is naturally 0 until D accepts.
    logic [N-1:0]  taps [D];

    logic          accept;
    logic [N:0]    diff;
    logic          sat_pos;
    logic          sat_neg;
    logic [N-1:0]  res_dat;
    logic          res_sat;

    logic          out_valid_q;
    logic [N-1:0]  out_data_q;
    logic          sat_flag_q;

    assign accept = bus.in_valid && !bus.clear;

    // Difference at N+1 bits so it cannot wrap before the clamp decision.
    always_comb begin
        diff = {bus.in_data[N-1], bus.in_data} - {taps[D-1][N-1], taps[D-1]};
    end

    // Positive clamp: the two top bits disagree with a positive sign (diff >= 2^(N-1)).
    // Negative clamp: true overflow below -2^(N-1), or exactly -2^(N-1) (top two
    // bits set, rest zero), which lies outside the symmetric range.
    always_comb begin
        sat_pos = !diff[N] && diff[N-1];
        sat_neg = diff[N] && (!diff[N-1] || (diff[N-2:0] == '0));
        res_dat = diff[N-1:0];
        res_sat = 1'b0;
        if (sat_pos) begin
            res_dat = POS_MAX;
            res_sat = 1'b1;
        end else if (sat_neg) begin
            res_dat = NEG_MAX;
            res_sat = 1'b1;
        end
    end

    // Delay line: shifts only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                taps[i] <= '0;
            end
        end else if (bus.clear) begin
            for (int i = 0; i < D; i++) begin
                taps[i] <= '0;
            end
        end else if (accept) begin
            taps[0] <= bus.in_data;
            for (int i = 1; i < D; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    // FILL counts accepts up to D; the D-th accept moves to RUN, which is
    // left only through clear or reset. The counter therefore stops at D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (bus.clear) begin
            state_nxt = FILL;
            cnt_nxt   = '0;
        end else if (accept) begin
            case (state)
                FILL: begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    cnt_nxt = cnt;
                end
                default: begin
                    state_nxt = FILL;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Result register: out_data/sat_flag hold the last result between accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_flag_q  <= 1'b0;
        end else if (bus.clear) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_flag_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= res_dat;
            sat_flag_q  <= res_sat;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat_flag  = sat_flag_q;
    assign bus.primed    = (state == RUN);

endmodule

// File: doc/sat_difference.md
Name: sat_difference

Overview:
- Streaming saturating differentiator (comb stage) for the digital filter datapath: y[n] = x[n] - x[n-D].
- Inverse partner of the saturating adder/integrator path; uses the same symmetric saturation rule.
- One registered pipeline stage; input delay line of depth D; sample-qualified by a valid strobe.

Parameters:
N, 4, data width in bits; two's complement signed; N >= 3
D, 1, differential delay in accepted samples; 1 <= D <= 8

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of delay line, counter and output valid
in_valid  input  1  in_data is a new sample this cycle
in_data  input  N  signed input sample x[n]
out_valid  output  1  out_data holds a new result; single-cycle pulse per accepted sample
out_data  output  N  signed saturated difference
sat_flag  output  1  result was clamped; qualified by out_valid
primed  output  1  at least D samples accepted since reset/clear

Behaviour:
- Reset (rst_n=0, asynchronous): delay line all zero; sample counter 0; out_valid=0; out_data=0; sat_flag=0; primed=0. Takes effect immediately, mid-operation included; the first accepted sample after release behaves as the first after power-up.
- Accept: rising edge with in_valid=1 and clear=0.
- Latency 1: the result for a sample accepted at edge k is on out_data, with out_valid=1, after edge k and until edge k+1.
- Throughput: one sample per cycle. No backpressure.
- Difference:
  - diff = in_data - tap, computed at N+1 bits, sign-extended.
  - tap = sample accepted D acceptances earlier, or 0 if fewer than D samples have been accepted.
- Delay line:
  - Shifts only on accept; in_valid=0 cycles leave it unchanged.
  - After an accept, tap[0] = the newly accepted sample.
- Symmetric saturation: MAX = 2^(N-1)-1.
  - diff > MAX: out_data = 0 followed by N-1 ones (+MAX); sat_flag=1.
  - diff < -MAX: out_data = 1, then N-2 zeros, then 1 (-MAX); sat_flag=1.
  - Otherwise: out_data = diff[N-1:0]; sat_flag=0.
  - The code 100..0 is never produced. Example: x = -2^(N-1) with tap 0 gives -MAX with sat_flag=1.
- Non-accept cycles:
  - out_valid=0.
  - out_data holds the last result.
  - sat_flag holds the last value.
- Counter:
  - Increments on each accept and saturates at D.
  - primed = (counter == D). primed is registered and rises on the edge of the D-th accept.
- Clear:
  - clear=1 at an edge zeroes the delay line and counter; out_valid=0, out_data=0, sat_flag=0, primed=0 after that edge.
  - clear has priority over a simultaneous in_valid: the sample is dropped and produces no output.
- States: FILL (counter < D, primed=0) to RUN (counter == D, primed=1) on the D-th accept. RUN returns to FILL only on clear or reset.

Test Plan:
1. N=4, D=1; accept 1, 3, 6 on consecutive edges -> out_data 1, 2, 3 on the following cycles; out_valid high 3 cycles; sat_flag=0; primed=1 from the first result on.
2. N=4, D=1; accept -8, then 7 -> first result -7 (0b1001) with sat_flag=1; second result 7 - (-8) = 15 -> +7 (0b0111) with sat_flag=1.
3. N=4, D=2; accept 5, idle 3 cycles, then accept 2, 4 -> results 5, 2, -1; out_valid low during idle; out_data holds 5 while idle; primed rises with the second accept.
4. N=4, D=2; after priming with 3, 4, assert clear together with in_valid (data 6) -> no out_valid next cycle; out_data=0, primed=0; next accept of 1 -> result 1.
5. N=4, D=1; accept 2 then 5, drop rst_n mid-cycle before the second result's edge -> outputs 0 immediately without waiting for clk; after release, accept 3 -> result 3, not 3-5.
6. N=8, D=8; accept ramp 0..15 -> first 8 results equal inputs 0..7; results 9..16 each equal 8; primed rises on the 8th accept; sat_flag never set.
